// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Forwarding select encoding used on ForwardAE / ForwardBE.
//   - Controller FSM state encoding.
//   - Hard-wired zero register index.
package hazard_ctrl_pkg;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read
  localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in MEM

  // x0 never carries a dependency: writes to it are discarded
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding compare for one EX-stage source register.
// Ports:
//   rs_e                   source register of the EX instruction
//   rd_m, regwrite_m       destination / write enable of the MEM instruction
//   rd_w, regwrite_w       destination / write enable of the WB instruction
//   fwd_sel                FWD_MEM, FWD_WB or FWD_RF
// MEM is younger than WB, so it wins when both match.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (regwrite_m && (rd_m != REG_X0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != REG_X0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard / scheduling controller of the 5-stage pipeline.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rs1_D, rs2_D              ID-stage source registers
//   rs1_E, rs2_E, rd_E        EX-stage source / destination registers
//   load_E, mispredict_E      EX instruction is a load / resolved a mispredict
//   mdu_op_E, mdu_done        EX holds a multi-cycle MDU op / MDU result valid
//   rd_M, rd_W, regwrite_M/W  MEM / WB destinations and write enables
//   StallF/D/E, FlushD/E/M    pipeline register hold / bubble strobes
//   ForwardAE, ForwardBE      EX operand forwarding selects
//   mdu_go                    one-cycle MDU start pulse
//   mdu_err                   sticky MDU timeout flag
//   stall_cnt, flush_cnt      saturating performance counters
//   state_dbg                 current controller FSM state
//
// MDU handshake: mdu_go is a single-cycle start strobe issued in RUN when the
// EX instruction is an MDU op; the MDU answers with a single-cycle mdu_done
// while the controller is BUSY. A mdu_done outside BUSY carries no meaning
// and is ignored. If no mdu_done arrives within MDU_TIMEOUT BUSY cycles the
// op is dropped from EX and mdu_err latches.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             load_E,
  input  logic             mispredict_E,
  input  logic             mdu_op_E,
  input  logic             mdu_done,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             regwrite_M,
  input  logic             regwrite_W,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mdu_go,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_t           state_dbg
);

  localparam int            TW       = $clog2(MDU_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_d;
  logic          lw_stall;
  logic          timeout;
  logic          mdu_hold;
  logic [1:0]    fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd_a (
    .rs_e       (rs1_E),
    .rd_m       (rd_M),
    .rd_w       (rd_W),
    .regwrite_m (regwrite_M),
    .regwrite_w (regwrite_W),
    .fwd_sel    (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs_e       (rs2_E),
    .rd_m       (rd_M),
    .rd_w       (rd_W),
    .regwrite_m (regwrite_M),
    .regwrite_w (regwrite_W),
    .fwd_sel    (fwd_b_raw)
  );

  assign state_dbg = state_q;

  always_comb begin
    lw_stall = load_E && (rd_E != REG_X0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    // A done arriving in the last allowed cycle still counts as completion.
    timeout  = (state_q == ST_BUSY) && (tmo_q == TMO_LAST) && !mdu_done;
    mdu_hold = ((state_q == ST_RUN) && mdu_op_E) ||
               ((state_q == ST_BUSY) && !mdu_done && !timeout);
  end

  // Hazard strobes and forwarding selects, forced quiet while in reset
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    mdu_go    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      ForwardAE = fwd_a_raw;
      ForwardBE = fwd_b_raw;
      mdu_go    = (state_q == ST_RUN) && mdu_op_E;
      if (mdu_hold) begin
        // Freeze everything up to EX; MEM receives bubbles meanwhile.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (timeout) begin
        // Abandon the op: bubble ID-EX, keep the younger instructions.
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (mispredict_E) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // FSM next state and timeout counter
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = mdu_err;
    case (state_q)
      ST_RUN: begin
        if (mdu_op_E) begin
          state_d = ST_BUSY;
          tmo_d   = '0;
        end
      end
      ST_BUSY: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else if (timeout) begin
          state_d = ST_RUN;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      mdu_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      mdu_err <= err_d;
      if (StallD && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      // FlushD is only ever raised by a mispredict
      if (FlushD && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, hand-written multi-cycle sequences
// and randomized traffic, all checked against a behavioural model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TMO  = 6;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic          load_E, mispredict_E, mdu_op_E, mdu_done, regwrite_M, regwrite_W;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_go, mdu_err;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;
  state_t        state_dbg;
  logic [6:0]    strb;

  assign strb = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_go};

  hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .load_E(load_E), .mispredict_E(mispredict_E), .mdu_op_E(mdu_op_E),
    .mdu_done(mdu_done), .rd_M(rd_M), .rd_W(rd_W),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mdu_go(mdu_go), .mdu_err(mdu_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy;   // an MDU op is in flight
  int m_n;      // BUSY cycles elapsed, counting the current one
  bit m_err;
  int m_sc, m_fc;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (regwrite_M && rd_M != 0 && rd_M == rs) return 2'd2;
    if (regwrite_W && rd_W != 0 && rd_W == rs) return 2'd1;
    return 2'd0;
  endfunction

  // Expected {StallF,StallD,StallE,FlushD,FlushE,FlushM,mdu_go} and selects
  task automatic model_eval(output logic [6:0] es, output logic [1:0] fa, output logic [1:0] fb);
    bit lw, tmo, hold;
    es = '0; fa = '0; fb = '0;
    if (!rst) begin
      fa   = fwd_ref(rs1_E);
      fb   = fwd_ref(rs2_E);
      lw   = load_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
      tmo  = m_busy && m_n == TMO && !mdu_done;
      hold = (!m_busy && mdu_op_E) || (m_busy && !mdu_done && !tmo);
      if (hold)              es[6:1] = 6'b111001;
      else if (tmo)          es[6:1] = 6'b110010;
      else if (mispredict_E) es[6:1] = 6'b000110;
      else if (lw)           es[6:1] = 6'b110010;
      es[0] = !m_busy && mdu_op_E;
    end
  endtask

  task automatic model_update(input logic [6:0] es);
    if (rst) begin
      m_busy = 0; m_n = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (es[5] && m_sc < CMAX) m_sc++;
      if (es[3] && m_fc < CMAX) m_fc++;
      if (!m_busy) begin
        if (mdu_op_E) begin m_busy = 1; m_n = 1; end
      end else if (mdu_done) begin
        m_busy = 0;
      end else if (m_n == TMO) begin
        m_busy = 0; m_err = 1;
      end else begin
        m_n++;
      end
    end
  endtask

  // Called at the negedge: compare everything against the model, then
  // advance across the active edge.
  task automatic adv();
    logic [6:0] es;
    logic [1:0] fa, fb;
    model_eval(es, fa, fb);
    chk("strobes",   32'(strb), 32'(es));
    chk("fwd_a",     32'(ForwardAE), 32'(fa));
    chk("fwd_b",     32'(ForwardBE), 32'(fb));
    chk("mdu_err",   32'(mdu_err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
    chk("busy",      32'(state_dbg == ST_BUSY), 32'(m_busy));
    @(posedge clk);
    model_update(es);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    adv();
  endtask

  // ---------------- driver ----------------
  task automatic clr_in();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    load_E = 0; mispredict_E = 0; mdu_op_E = 0; mdu_done = 0;
    regwrite_M = 0; regwrite_W = 0;
  endtask

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, misp, rw_m, rw_w;
    logic [5:0] exp_strb;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [4:0] r1d, r2d, r1e, r2e, rde, rdm, rdw,
                         input logic ld, mp, rwm, rww,
                         input logic [5:0] es, input logic [1:0] fa, fb);
    vec_t v;
    v.rs1_d = r1d; v.rs2_d = r2d; v.rs1_e = r1e; v.rs2_e = r2e; v.rd_e = rde;
    v.rd_m = rdm; v.rd_w = rdw; v.load_e = ld; v.misp = mp; v.rw_m = rwm; v.rw_w = rww;
    v.exp_strb = es; v.exp_fa = fa; v.exp_fb = fb;
    vq.push_back(v);
  endtask

  int gos, stall_cycles;

  initial begin
    // ---- vector table: r1d r2d r1e r2e rde rdm rdw  ld mp rwm rww  strobes fa fb
    add_vec(0, 0, 7, 7, 0, 7, 7, 0, 0, 1, 1, 6'b000000, 2'd2, 2'd2); // MEM beats WB
    add_vec(0, 0, 7, 7, 0, 7, 7, 0, 0, 0, 1, 6'b000000, 2'd1, 2'd1); // MEM not writing
    add_vec(0, 0, 0, 7, 0, 0, 7, 0, 0, 1, 1, 6'b000000, 2'd0, 2'd1); // x0 never forwards
    add_vec(0, 0, 3, 9, 0, 3, 9, 0, 0, 1, 1, 6'b000000, 2'd2, 2'd1); // split sources
    add_vec(5, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0, 6'b000110, 2'd0, 2'd0); // mispredict over lw
    add_vec(1, 12, 0, 0, 12, 0, 0, 1, 0, 0, 0, 6'b110010, 2'd0, 2'd0); // lw via rs2
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 2'd0, 2'd0); // load to x0
    add_vec(4, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 6'b000000, 2'd0, 2'd0); // non-load match
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000110, 2'd0, 2'd0); // plain mispredict

    // ---- reset: outputs quiet even with every hazard present
    clr_in();
    rst = 1;
    load_E = 1; rd_E = 5; rs1_D = 5; mispredict_E = 1; mdu_op_E = 1;
    rs1_E = 7; rd_M = 7; regwrite_M = 1;
    @(negedge clk);
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    @(posedge clk);
    model_update(7'd0);
    #1;
    cyc();
    clr_in();
    rst = 0;
    @(negedge clk);
    chk("rst_state_run", 32'(state_dbg == ST_RUN), 32'd1);
    chk("rst_counters", 32'({stall_cnt, flush_cnt}), 32'd0);
    chk("rst_err", 32'(mdu_err), 32'd0);
    adv();

    // ---- load-use
    load_E = 1; rd_E = 5; rs1_D = 5;
    @(negedge clk);
    chk("lu_strobes", 32'(strb), 32'(7'b1100100));
    chk("lu_cnt_before", 32'(stall_cnt), 32'd0);
    adv();
    rd_E = 0; rs1_D = 0;
    @(negedge clk);
    chk("lu_cnt_after", 32'(stall_cnt), 32'd1);
    chk("lu_x0_strobes", 32'(strb), 32'd0);
    adv();

    // ---- mispredict vs load-use in the same cycle
    rd_E = 5; rs1_D = 5; mispredict_E = 1;
    @(negedge clk);
    chk("mp_lw_strobes", 32'(strb), 32'(7'b0001100));
    adv();
    clr_in();
    @(negedge clk);
    chk("mp_lw_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("mp_lw_flush_cnt", 32'(flush_cnt), 32'd1);
    adv();

    // ---- table vectors
    foreach (vq[i]) begin
      rs1_D = vq[i].rs1_d; rs2_D = vq[i].rs2_d; rs1_E = vq[i].rs1_e; rs2_E = vq[i].rs2_e;
      rd_E = vq[i].rd_e; rd_M = vq[i].rd_m; rd_W = vq[i].rd_w;
      load_E = vq[i].load_e; mispredict_E = vq[i].misp;
      regwrite_M = vq[i].rw_m; regwrite_W = vq[i].rw_w;
      @(negedge clk);
      chk($sformatf("vec%0d_strobes", i), 32'(strb[6:1]), 32'(vq[i].exp_strb));
      chk($sformatf("vec%0d_go", i), 32'(mdu_go), 32'd0);
      chk($sformatf("vec%0d_fwd_a", i), 32'(ForwardAE), 32'(vq[i].exp_fa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(ForwardBE), 32'(vq[i].exp_fb));
      adv();
    end
    clr_in();

    // ---- MDU handshake, done 5 cycles after go; a mispredict is ignored
    gos = 0; stall_cycles = 0;
    mdu_op_E = 1; mispredict_E = 1;
    for (int k = 0; k <= 5; k++) begin
      mdu_done = (k == 5);
      @(negedge clk);
      gos += int'(mdu_go);
      stall_cycles += int'(StallE && FlushM);
      if (k == 0)      chk("hs_go_strobes", 32'(strb), 32'(7'b1110011));
      else if (k < 5)  chk("hs_hold_strobes", 32'(strb), 32'(7'b1110010));
      else             chk("hs_done_stalls", 32'(strb[6:4]), 32'd0);
      adv();
    end
    clr_in();
    @(negedge clk);
    chk("hs_go_count", 32'(gos), 32'd1);
    chk("hs_stall_cycles", 32'(stall_cycles), 32'd5);
    chk("hs_state_run", 32'(state_dbg == ST_RUN), 32'd1);
    adv();

    // ---- done arriving in the last allowed BUSY cycle beats the timeout
    mdu_op_E = 1;
    for (int k = 0; k <= TMO; k++) begin
      mdu_done = (k == TMO);
      @(negedge clk);
      if (k == TMO) chk("edge_done_strobes", 32'(strb), 32'd0);
      adv();
    end
    clr_in();
    @(negedge clk);
    chk("edge_no_err", 32'(mdu_err), 32'd0);
    chk("edge_state_run", 32'(state_dbg == ST_RUN), 32'd1);
    adv();

    // ---- timeout: no done ever
    mdu_op_E = 1;
    for (int k = 0; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO) begin
        chk("tmo_strobes", 32'(strb), 32'(7'b1100100));
        chk("tmo_err_before", 32'(mdu_err), 32'd0);
      end
      adv();
    end
    mdu_op_E = 0;
    @(negedge clk);
    chk("tmo_err_set", 32'(mdu_err), 32'd1);
    chk("tmo_state_run", 32'(state_dbg == ST_RUN), 32'd1);
    adv();
    cyc();
    @(negedge clk);
    chk("tmo_err_sticky", 32'(mdu_err), 32'd1);
    adv();

    // ---- counter saturation (fresh counters first)
    rst = 1;
    cyc();
    rst = 0;
    load_E = 1; rd_E = 9; rs2_D = 9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("sat_stall_cnt", 32'(stall_cnt), 32'((k < CMAX) ? k : CMAX));
      adv();
    end
    clr_in();
    @(negedge clk);
    chk("sat_stall_final", 32'(stall_cnt), 32'(CMAX));
    adv();

    // ---- reset in the middle of BUSY
    mdu_op_E = 1;
    cyc(); cyc(); cyc();
    rst = 1;
    @(negedge clk);
    chk("rb_rst_strobes", 32'(strb), 32'd0);
    adv();
    rst = 0; mdu_op_E = 0;
    @(negedge clk);
    chk("rb_state_run", 32'(state_dbg == ST_RUN), 32'd1);
    chk("rb_counters", 32'({stall_cnt, flush_cnt}), 32'd0);
    chk("rb_err", 32'(mdu_err), 32'd0);
    chk("rb_no_go", 32'(mdu_go), 32'd0);
    adv();

    // ---- randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst          = ($urandom_range(0, 60) == 0);
      rs1_D        = 5'($urandom_range(0, 3));
      rs2_D        = 5'($urandom_range(0, 3));
      rs1_E        = 5'($urandom_range(0, 3));
      rs2_E        = 5'($urandom_range(0, 3));
      rd_E         = 5'($urandom_range(0, 3));
      rd_M         = 5'($urandom_range(0, 3));
      rd_W         = 5'($urandom_range(0, 3));
      load_E       = $urandom_range(0, 2) == 0;
      mispredict_E = $urandom_range(0, 4) == 0;
      regwrite_M   = $urandom_range(0, 1) == 1;
      regwrite_W   = $urandom_range(0, 1) == 1;
      // an op in flight stays parked in EX until it completes
      mdu_op_E     = m_busy ? 1'b1 : ($urandom_range(0, 5) == 0);
      mdu_done     = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cyc();
    end
    clr_in();
    rst = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
